weight_fetch_ctrl: RTL

Weight fetch controller sitting directly upstream of the weight FIFO. It accepts a command (base address, tile count) and streams 32-byte weight rows out of the synchronous weight SRAM, one row per cycle. It drives the FIFO's write strobe and 32-lane byte data, and signals completion back to the top-level control unit. Stall input lets the controller insert bubbles; the FIFO absorbs these as invalid slots.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/weight_addr_gen.sv | 52 +++++
 rtl/weight_fetch_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: row geometry, byte/row typedefs and the weight-fetch FSM encoding.
package tpu_pkg;

  localparam int ROWS = 32;

  typedef logic [7:0] byte_t;
  typedef byte_t      row_t [ROWS];

  typedef enum logic [1:0] {
    WF_IDLE  = 2'd0,
    WF_ISSUE = 2'd1,
    WF_FLUSH = 2'd2
  } wf_state_e;

endpackage

// File: rtl/weight_addr_gen.sv
// Row/tile walker for weight fetches: holds the running SRAM address and flags
// the final row of the final tile.
module weight_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int ROWS   = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_tiles,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ROW_W-1:0]  row_q;
  logic [CNT_W-1:0]  tile_q;
  logic [CNT_W-1:0]  last_tile_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      last_tile_q <= '0;
    end else if (load) begin
      addr_q      <= base_addr;
      row_q       <= '0;
      tile_q      <= '0;
      last_tile_q <= num_tiles - CNT_W'(1);
    end else if (advance) begin
      // Address wraps silently at 2^ADDR_W; the tile count only steps on row wrap.
      addr_q <= addr_q + ADDR_W'(1);
      if (row_q == ROW_LAST) begin
        row_q  <= '0;
        tile_q <= tile_q + CNT_W'(1);
      end else begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

  assign addr = addr_q;
  assign last = (row_q == ROW_LAST) && (tile_q == last_tile_q);

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: streams ROWS-byte rows from the weight SRAM into the
// weight FIFO, one row per unstalled cycle, and pulses done when the command ends.
module weight_fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int ROWS   = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  num_tiles_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  tpu_pkg::byte_t    mem_data_i [ROWS],
  output logic              fifo_write_o,
  output tpu_pkg::byte_t    fifo_data_o [ROWS]
);

  tpu_pkg::wf_state_e state_q, state_d;
  logic               done_q, done_d;
  logic               rd_q;
  logic               load, advance, rd_en;
  logic [ADDR_W-1:0]  cur_addr;
  logic               last_row;

  weight_addr_gen #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load),
    .advance   (advance),
    .base_addr (base_addr_i),
    .num_tiles (num_tiles_i),
    .addr      (cur_addr),
    .last      (last_row)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= tpu_pkg::WF_IDLE;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rd_q    <= rd_en;
    end
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      tpu_pkg::WF_IDLE: begin
        if (start_i) begin
          if (num_tiles_i == '0) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = tpu_pkg::WF_ISSUE;
          end
        end
      end
      tpu_pkg::WF_ISSUE: begin
        if (!stall_i) begin
          rd_en   = 1'b1;
          advance = 1'b1;
          if (last_row) state_d = tpu_pkg::WF_FLUSH;
        end
      end
      tpu_pkg::WF_FLUSH: begin
        // The final read's data lands this cycle; completion follows.
        state_d = tpu_pkg::WF_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = tpu_pkg::WF_IDLE;
    endcase
  end

  assign busy_o       = (state_q != tpu_pkg::WF_IDLE);
  assign done_o       = done_q;
  assign mem_rd_en_o  = rd_en;
  assign mem_addr_o   = (state_q == tpu_pkg::WF_ISSUE) ? cur_addr : '0;
  assign fifo_write_o = rd_q;

  // Bubbles reach the FIFO as zeroed, invalid slots rather than stale SRAM data.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      fifo_data_o[i] = rd_q ? mem_data_i[i] : 8'h00;
    end
  end

endmodule
